// File: rtl/button_pio_responder_if.sv
// Avalon-MM slave bus bundle for button_pio_responder: 2-bit word address, 32-bit data,
// fixed one-cycle read latency, no waitrequest.
interface button_pio_responder_if;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned DATA_W = 32;

   logic [ADDR_W-1:0] avs_address;
   logic              avs_read;
   logic              avs_write;
   logic [DATA_W-1:0] avs_writedata;
   logic [DATA_W-1:0] avs_readdata;

   modport master (output avs_address, avs_read, avs_write, avs_writedata,
                   input  avs_readdata);
   modport slave  (input  avs_address, avs_read, avs_write, avs_writedata,
                   output avs_readdata);
endinterface

// File: rtl/button_pio_responder.sv
// Push-button PIO responder: synchronise/normalise pins, capture press edges, level irq.
// Optional per-bit debounce filter enabled by `BUTTON_PIO_DEBOUNCE_EN.
module button_pio_responder #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned ACTIVE_LOW      = 1,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic                     clk_clk,
   input  logic                     reset_reset_n,
   input  logic [WIDTH-1:0]         button_pio_export,
   button_pio_responder_if.slave    avs,
   output logic                     irq
);

   localparam logic [WIDTH-1:0] IDLE_PINS = (ACTIVE_LOW != 0) ? '1 : '0;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd1;
   localparam logic [1:0] ADDR_EDGECAP = 2'd2;

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] norm;
   logic [WIDTH-1:0] pressed;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] wr_bits;
   logic [WIDTH-1:0] clr_bits;
   logic             wr_mask;
   logic [31:0]      rd_value;
   logic             unused_wdata;

   // Two-flop synchroniser; resets to the idle pin level so reset release is edge-free
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1 <= IDLE_PINS;
         sync2 <= IDLE_PINS;
      end else begin
         sync1 <= button_pio_export;
         sync2 <= sync1;
      end
   end

   assign norm = sync2 ^ IDLE_PINS;

`ifdef BUTTON_PIO_DEBOUNCE_EN
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] cnt [WIDTH];

   // Per-bit stability counter: pressed follows norm only after a full run of disagreement
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         pressed <= '0;
         for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (norm[i] != pressed[i]) begin
               if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  pressed[i] <= norm[i];
                  cnt[i]     <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end
`else
   localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

   assign pressed = norm;
`endif

   assign rise         = pressed & ~prev;
   assign wr_bits      = avs.avs_writedata[WIDTH-1:0];
   assign wr_mask      = avs.avs_write && (avs.avs_address == ADDR_IRQMASK);
   assign clr_bits     = (avs.avs_write && (avs.avs_address == ADDR_EDGECAP)) ? wr_bits : '0;
   assign unused_wdata = ^avs.avs_writedata;

   // Read mux over the pre-write register values
   always_comb begin
      rd_value = '0;
      case (avs.avs_address)
         ADDR_DATA:    rd_value = 32'(pressed);
         ADDR_IRQMASK: rd_value = 32'(irqmask);
         ADDR_EDGECAP: rd_value = 32'(edgecap);
         default:      rd_value = {31'd0, irq};
      endcase
   end

   // Register file, edge capture (set beats clear) and registered outputs
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         prev             <= '0;
         irqmask          <= '0;
         edgecap          <= '0;
         irq              <= 1'b0;
         avs.avs_readdata <= '0;
      end else begin
         prev    <= pressed;
         edgecap <= (edgecap & ~clr_bits) | rise;
         irq     <= |(edgecap & irqmask);
         if (wr_mask) irqmask <= wr_bits;
         if (avs.avs_read) avs.avs_readdata <= rd_value;
      end
   end

endmodule

// File: tb/tb_button_pio_responder.sv
// Self-checking bench for button_pio_responder against a cycle-level behavioural model.
module tb_button_pio_responder;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned DBC   = 8;
`ifdef BUTTON_PIO_DEBOUNCE_EN
   localparam int SET_LAT = DBC + 2;
`else
   localparam int SET_LAT = 2;
`endif

   logic             clk_clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] pins;
   logic             irq;

   button_pio_responder_if avs ();

   button_pio_responder #(
      .WIDTH(WIDTH), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DBC)
   ) dut (
      .clk_clk(clk_clk),
      .reset_reset_n(rst_n),
      .button_pio_export(pins),
      .avs(avs),
      .irq(irq)
   );

   always #5 clk_clk = ~clk_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: sample history (newest first), pressed history, registers
   logic [WIDTH-1:0] s_hist  [0:DBC];
   logic [WIDTH-1:0] ph_hist [0:1];
   logic [WIDTH-1:0] m_mask;
   logic [WIDTH-1:0] m_ec;
   logic             m_irq;
   logic [31:0]      m_rd;

   task automatic model_reset();
      for (int j = 0; j <= int'(DBC); j++) s_hist[j] = '0;
      ph_hist[0] = '0;
      ph_hist[1] = '0;
      m_mask = '0;
      m_ec   = '0;
      m_irq  = 1'b0;
      m_rd   = '0;
   endtask

   // One clock: advance the model on the rising edge, return at the falling edge
   task automatic tick();
      logic [WIDTH-1:0] p_new, rise, clr;
      logic [31:0]      rv;
      logic             irq_new;
      @(posedge clk_clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         case (avs.avs_address)
            2'd0:    rv = 32'(ph_hist[0]);
            2'd1:    rv = 32'(m_mask);
            2'd2:    rv = 32'(m_ec);
            default: rv = {31'd0, m_irq};
         endcase
`ifdef BUTTON_PIO_DEBOUNCE_EN
         p_new = ph_hist[0];
         for (int b = 0; b < int'(WIDTH); b++) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int j = 1; j <= int'(DBC); j++)
               if (s_hist[j][b] == ph_hist[0][b]) all_diff = 1'b0;
            if (all_diff) p_new[b] = ~ph_hist[0][b];
         end
`else
         p_new = s_hist[0];
`endif
         rise    = ph_hist[0] & ~ph_hist[1];
         clr     = (avs.avs_write && avs.avs_address == 2'd2) ? avs.avs_writedata[WIDTH-1:0] : '0;
         irq_new = |(m_ec & m_mask);
         if (avs.avs_read) m_rd = rv;
         if (avs.avs_write && avs.avs_address == 2'd1) m_mask = avs.avs_writedata[WIDTH-1:0];
         m_ec  = (m_ec & ~clr) | rise;
         m_irq = irq_new;
         for (int j = int'(DBC); j > 0; j--) s_hist[j] = s_hist[j-1];
         s_hist[0]  = ~pins;
         ph_hist[1] = ph_hist[0];
         ph_hist[0] = p_new;
      end
      @(negedge clk_clk);
   endtask

   task automatic bus(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] wd);
      avs.avs_read      = rd;
      avs.avs_write     = wr;
      avs.avs_address   = a;
      avs.avs_writedata = wd;
      tick();
      avs.avs_read  = 1'b0;
      avs.avs_write = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pins  = 4'hF;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
      end
      rst_n = 1'b1;
      tick();
      for (int a = 0; a < 4; a++) begin
         bus(1'b1, 1'b0, 2'(a), 32'd0);
         n_tests++;
         if (avs.avs_readdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_read%0d: got %h want 0", a, avs.avs_readdata);
         end
         n_tests++;
         if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq_post: got %b want 0", irq); end
      end
   endtask

   task automatic test_press_capture();
      bus(1'b0, 1'b1, 2'd1, 32'h2);
      pins = 4'hD;
      for (int i = 0; i < int'(DBC) + 6; i++) begin
         tick();
         n_tests++;
         if (irq !== m_irq) begin n_fail++; $display("FAIL press_irq_t%0d: got %b want %b", i, irq, m_irq); end
`ifndef BUTTON_PIO_DEBOUNCE_EN
         if (i == 2 || i == 3) begin
            n_tests++;
            if (irq !== (i == 3)) begin n_fail++; $display("FAIL press_irq_edge%0d: got %b want %b", i, irq, i == 3); end
         end
`endif
      end
      bus(1'b1, 1'b0, 2'd2, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== 32'h2 || m_rd !== 32'h2) begin
         n_fail++; $display("FAIL press_edgecap: got %h model %h want 2", avs.avs_readdata, m_rd);
      end
      bus(1'b1, 1'b0, 2'd0, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== 32'h2) begin n_fail++; $display("FAIL press_data: got %h want 2", avs.avs_readdata); end
   endtask

   task automatic test_w1c_simultaneous();
      pins = 4'hF;
      ticks(int'(DBC) + 6);
      pins = 4'hE;
      ticks(SET_LAT);
      bus(1'b0, 1'b1, 2'd2, 32'h3);
      bus(1'b1, 1'b0, 2'd2, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== 32'h1 || m_rd !== 32'h1) begin
         n_fail++; $display("FAIL w1c_set_wins: got %h model %h want 1", avs.avs_readdata, m_rd);
      end
   endtask

   task automatic test_mask_gating();
      bus(1'b0, 1'b1, 2'd1, 32'h0);
      pins = 4'hA;
      ticks(int'(DBC) + 6);
      pins = 4'hF;
      ticks(int'(DBC) + 6);
      bus(1'b1, 1'b0, 2'd2, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== 32'h5) begin n_fail++; $display("FAIL mask_ec5: got %h want 5", avs.avs_readdata); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq_off: got %b want 0", irq); end
      bus(1'b0, 1'b1, 2'd1, 32'h4);
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq_same: got %b want 0", irq); end
      tick();
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_irq_on: got %b want 1", irq); end
      bus(1'b0, 1'b1, 2'd2, 32'h4);
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL clr_irq_same: got %b want 1", irq); end
      tick();
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL clr_irq_off: got %b want 0", irq); end
      bus(1'b1, 1'b0, 2'd3, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL status_zero: got %h want 0", avs.avs_readdata); end
   endtask

   task automatic test_back_to_back();
      bus(1'b1, 1'b1, 2'd1, 32'hFFFF_FFF9);
      n_tests++;
      if (avs.avs_readdata !== 32'h4) begin n_fail++; $display("FAIL rw_prewrite: got %h want 4", avs.avs_readdata); end
      bus(1'b1, 1'b0, 2'd1, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== 32'h9) begin n_fail++; $display("FAIL rw_postwrite: got %h want 9", avs.avs_readdata); end
      bus(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF);
      bus(1'b1, 1'b0, 2'd3, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== 32'h1) begin n_fail++; $display("FAIL status_irq: got %h want 1", avs.avs_readdata); end
      bus(1'b1, 1'b0, 2'd0, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== m_rd) begin n_fail++; $display("FAIL data_ro: got %h want %h", avs.avs_readdata, m_rd); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) pins = 4'($urandom);
         bus(1'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom), $urandom);
         n_tests++;
         if (avs.avs_readdata !== m_rd || irq !== m_irq) begin
            n_fail++;
            $display("FAIL random%0d: rd %h irq %b want rd %h irq %b", i, avs.avs_readdata, irq, m_rd, m_irq);
         end
      end
   endtask

`ifdef BUTTON_PIO_DEBOUNCE_EN
   task automatic test_debounce();
      bus(1'b0, 1'b1, 2'd1, 32'h0);
      pins = 4'hF;
      ticks(int'(DBC) + 6);
      bus(1'b0, 1'b1, 2'd2, 32'hF);
      pins = 4'hB;
      ticks(5);
      pins = 4'hF;
      ticks(12);
      bus(1'b1, 1'b0, 2'd0, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL bounce_data: got %h want 0", avs.avs_readdata); end
      bus(1'b1, 1'b0, 2'd2, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL bounce_ec: got %h want 0", avs.avs_readdata); end
      pins = 4'hB;
      ticks(5);
      bus(1'b1, 1'b0, 2'd0, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL deb_early: got %h want 0", avs.avs_readdata); end
      ticks(6);
      bus(1'b1, 1'b0, 2'd0, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== 32'h4) begin n_fail++; $display("FAIL deb_data: got %h want 4", avs.avs_readdata); end
      bus(1'b1, 1'b0, 2'd2, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== 32'h4) begin n_fail++; $display("FAIL deb_ec: got %h want 4", avs.avs_readdata); end
   endtask
`endif

   task automatic test_reset_mid();
      bus(1'b0, 1'b1, 2'd1, 32'hF);
      pins = 4'hF;
      ticks(int'(DBC) + 6);
      pins = 4'h0;
      ticks(int'(DBC) + 6);
      pins = 4'hF;
      ticks(int'(DBC) + 6);
      bus(1'b1, 1'b0, 2'd2, 32'd0);
      n_tests++;
      if (avs.avs_readdata !== 32'hF) begin n_fail++; $display("FAIL mid_ec_full: got %h want F", avs.avs_readdata); end
      pins = 4'hD;
      ticks(4);
      rst_n = 1'b0;
      model_reset();
      tick();
      rst_n = 1'b1;
      pins  = 4'hF;
      for (int i = 0; i < int'(DBC) + 6; i++) begin
         tick();
         n_tests++;
         if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq%0d: got %b want 0", i, irq); end
      end
      for (int a = 0; a < 4; a++) begin
         bus(1'b1, 1'b0, 2'(a), 32'd0);
         n_tests++;
         if (avs.avs_readdata !== 32'd0) begin n_fail++; $display("FAIL mid_read%0d: got %h want 0", a, avs.avs_readdata); end
      end
   endtask

   initial begin
      avs.avs_read      = 1'b0;
      avs.avs_write     = 1'b0;
      avs.avs_address   = 2'd0;
      avs.avs_writedata = 32'd0;
      rst_n = 1'b0;
      pins  = 4'hF;
      @(negedge clk_clk);
      test_reset();
      test_press_capture();
      test_w1c_simultaneous();
      test_mask_gating();
      test_back_to_back();
      test_random();
`ifdef BUTTON_PIO_DEBOUNCE_EN
      test_debounce();
`endif
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
